hmmm_mem_responder: RTL and testbench

Memory-side responder for the HMMM processor's external memory bus. It owns a 256×16 word store, answers processor reads and accepts processor writes. Before the processor runs, it accepts a program image over a valid/ready loader port. It holds the processor in reset until loading finishes, then releases it. It flags and captures the first processor store as the test-complete event. It sits on the board side of the bus, taking the place of the bench SRAM plus its file preload.

---
 rtl/hmmm_pkg.sv | 20 ++
 rtl/hmmm_mem_responder_if.sv | 35 +++
 rtl/hmmm_wordmem.sv | 37 +++
 rtl/hmmm_mem_responder.sv | 126 ++++++++++++
 tb/tb_hmmm_mem_responder.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hmmm_pkg.sv
// Shared types and constants for the HMMM memory responder block.
package hmmm_pkg;

  localparam int HMMM_ADDR_W = 8;
  localparam int HMMM_DATA_W = 16;

  // Responder life cycle: program load, release hold-off, processor run, halted.
  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    RUN,
    DONE
  } resp_state_t;

  // Number of bits needed to hold values 0..max_val (never less than 1).
  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hmmm_mem_responder_if.sv
// Loader stream plus processor memory bus seen by the responder.
interface hmmm_mem_responder_if
  import hmmm_pkg::*;
#(
  parameter int ADDR_WIDTH = HMMM_ADDR_W,
  parameter int DATA_WIDTH = HMMM_DATA_W
);

  // Program loader stream
  logic                  ld_valid;
  logic                  ld_ready;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;

  // Processor side of the external memory bus
  logic                  cpu_reset;
  logic [ADDR_WIDTH-1:0] adr;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rdata_oe;

  // Loader and processor: the party driving requests
  modport master (
    output ld_valid, ld_data, ld_last, adr, mem_write, wdata,
    input  ld_ready, cpu_reset, rdata, rdata_oe
  );

  // Memory responder
  modport slave (
    input  ld_valid, ld_data, ld_last, adr, mem_write, wdata,
    output ld_ready, cpu_reset, rdata, rdata_oe
  );

endinterface

// File: rtl/hmmm_wordmem.sv
// Single-port word store: one write port and one registered read port
// sharing a single address. Contents survive reset; only the read
// register is cleared.
module hmmm_wordmem
  import hmmm_pkg::*;
#(
  parameter int ADDR_WIDTH = HMMM_ADDR_W,
  parameter int DATA_WIDTH = HMMM_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array write; kept free of reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read; holds its value on cycles without a read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/hmmm_mem_responder.sv
// Board-side memory responder for the HMMM processor: loads a program
// image, holds the processor in reset until loading is complete, then
// serves reads/writes and captures the first store as the test result.
module hmmm_mem_responder
  import hmmm_pkg::*;
#(
  parameter int ADDR_WIDTH    = HMMM_ADDR_W,
  parameter int DATA_WIDTH    = HMMM_DATA_W,
  parameter int RELEASE_DELAY = 2,
  parameter int HALT_ON_WRITE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  hmmm_mem_responder_if.slave   bus,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] done_adr,
  output logic [DATA_WIDTH-1:0] done_data,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int CNT_W = bits_for(RELEASE_DELAY - 1);

  resp_state_t           state;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [CNT_W-1:0]      delay_cnt;
  logic                  cpu_reset_reg;
  logic                  rdata_oe_reg;

  logic                  ld_ready;
  logic                  ld_fire;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Ready depends only on state, and is forced low while reset is held
  assign ld_ready = (state == LOAD) && reset;
  assign ld_fire  = bus.ld_valid && ld_ready;

  // Processor strobes only count while running
  assign cpu_rd = (state == RUN) && !bus.mem_write;
  assign cpu_wr = (state == RUN) && bus.mem_write;

  // The single RAM port belongs to the loader during LOAD, else the processor
  assign mem_we    = ld_fire || cpu_wr;
  assign mem_addr  = (state == LOAD) ? wptr : bus.adr;
  assign mem_wdata = (state == LOAD) ? bus.ld_data : bus.wdata;

  assign bus.ld_ready  = ld_ready;
  assign bus.cpu_reset = cpu_reset_reg;
  assign bus.rdata_oe  = rdata_oe_reg;

  hmmm_wordmem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wordmem (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (cpu_rd),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (bus.rdata)
  );

  // Control FSM with load pointer, release delay and first-store capture.
  // cpu_reset is updated from the current state, so release lands one edge
  // after RUN is entered, while a halting write re-asserts it on its own edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= LOAD;
      wptr          <= '0;
      load_count    <= '0;
      delay_cnt     <= '0;
      cpu_reset_reg <= 1'b1;
      rdata_oe_reg  <= 1'b0;
      done          <= 1'b0;
      done_adr      <= '0;
      done_data     <= '0;
    end else begin
      rdata_oe_reg <= cpu_rd;
      case (state)
        LOAD: begin
          cpu_reset_reg <= 1'b1;
          if (ld_fire) begin
            wptr       <= wptr + ADDR_WIDTH'(1);
            load_count <= load_count + (ADDR_WIDTH + 1)'(1);
            // A full store ends the image even without ld_last
            if (bus.ld_last || (wptr == '1)) begin
              state     <= HOLD;
              delay_cnt <= CNT_W'(RELEASE_DELAY - 1);
            end
          end
        end
        HOLD: begin
          cpu_reset_reg <= 1'b1;
          if (delay_cnt == '0) begin
            state <= RUN;
          end else begin
            delay_cnt <= delay_cnt - CNT_W'(1);
          end
        end
        RUN: begin
          cpu_reset_reg <= 1'b0;
          if (bus.mem_write && !done) begin
            done      <= 1'b1;
            done_adr  <= bus.adr;
            done_data <= bus.wdata;
            if (HALT_ON_WRITE != 0) begin
              state         <= DONE;
              cpu_reset_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          cpu_reset_reg <= 1'b1;
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hmmm_mem_responder.sv
// Scoreboard bench for hmmm_mem_responder: one halting and one free-running
// instance share the request stimulus and are enabled by separate resets.
module tb_hmmm_mem_responder;
  import hmmm_pkg::*;

  typedef struct packed {
    logic [HMMM_ADDR_W-1:0] a;
    logic [HMMM_DATA_W-1:0] d;
  } cap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_halt, rst_free;
  logic                   ld_valid, ld_last, mem_write;
  logic [HMMM_DATA_W-1:0] ld_data, wdata;
  logic [HMMM_ADDR_W-1:0] adr;

  logic                   done_h, done_f;
  logic [HMMM_ADDR_W-1:0] done_adr_h, done_adr_f;
  logic [HMMM_DATA_W-1:0] done_data_h, done_data_f;
  logic [HMMM_ADDR_W:0]   load_count_h, load_count_f;

  int checks = 0;
  int errors = 0;
  int tgt = 0;  // 0: halting instance under test, 1: free-running instance

  logic [HMMM_DATA_W-1:0] rd_q_h[$];
  logic [HMMM_DATA_W-1:0] rd_q_f[$];
  cap_t                   cap_q_h[$];
  cap_t                   cap_q_f[$];

  hmmm_mem_responder_if bus_halt ();
  hmmm_mem_responder_if bus_free ();

  assign bus_halt.ld_valid  = ld_valid;
  assign bus_halt.ld_data   = ld_data;
  assign bus_halt.ld_last   = ld_last;
  assign bus_halt.adr       = adr;
  assign bus_halt.mem_write = mem_write;
  assign bus_halt.wdata     = wdata;
  assign bus_free.ld_valid  = ld_valid;
  assign bus_free.ld_data   = ld_data;
  assign bus_free.ld_last   = ld_last;
  assign bus_free.adr       = adr;
  assign bus_free.mem_write = mem_write;
  assign bus_free.wdata     = wdata;

  hmmm_mem_responder #(
    .RELEASE_DELAY (2),
    .HALT_ON_WRITE (1)
  ) dut_halt (
    .clk        (clk),
    .reset      (rst_halt),
    .bus        (bus_halt),
    .done       (done_h),
    .done_adr   (done_adr_h),
    .done_data  (done_data_h),
    .load_count (load_count_h)
  );

  hmmm_mem_responder #(
    .RELEASE_DELAY (2),
    .HALT_ON_WRITE (0)
  ) dut_free (
    .clk        (clk),
    .reset      (rst_free),
    .bus        (bus_free),
    .done       (done_f),
    .done_adr   (done_adr_f),
    .done_data  (done_data_f),
    .load_count (load_count_f)
  );

  function automatic logic sel_cpu_reset();
    return (tgt != 0) ? bus_free.cpu_reset : bus_halt.cpu_reset;
  endfunction
  function automatic logic sel_ld_ready();
    return (tgt != 0) ? bus_free.ld_ready : bus_halt.ld_ready;
  endfunction
  function automatic logic [31:0] sel_load_count();
    return (tgt != 0) ? 32'(load_count_f) : 32'(load_count_h);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s", msg);
  endtask

  // Compare every read response and every done rise against the queues
  task automatic monitor();
    logic prev_h = 1'b0;
    logic prev_f = 1'b0;
    logic [HMMM_DATA_W-1:0] e;
    cap_t c;
    forever begin
      @(negedge clk);
      if (bus_halt.rdata_oe) begin
        if (rd_q_h.size() == 0) fail($sformatf("halt_rd_unexpected rdata=%0h expected=no read", bus_halt.rdata));
        else begin e = rd_q_h.pop_front(); check("halt_rdata", 32'(bus_halt.rdata), 32'(e)); end
      end
      if (bus_free.rdata_oe) begin
        if (rd_q_f.size() == 0) fail($sformatf("free_rd_unexpected rdata=%0h expected=no read", bus_free.rdata));
        else begin e = rd_q_f.pop_front(); check("free_rdata", 32'(bus_free.rdata), 32'(e)); end
      end
      if (done_h && !prev_h) begin
        if (cap_q_h.size() == 0) fail($sformatf("halt_done_unexpected done_adr=%0h expected=no done", done_adr_h));
        else begin
          c = cap_q_h.pop_front();
          check("halt_done_adr", 32'(done_adr_h), 32'(c.a));
          check("halt_done_data", 32'(done_data_h), 32'(c.d));
        end
      end
      if (done_f && !prev_f) begin
        if (cap_q_f.size() == 0) fail($sformatf("free_done_unexpected done_adr=%0h expected=no done", done_adr_f));
        else begin
          c = cap_q_f.pop_front();
          check("free_done_adr", 32'(done_adr_f), 32'(c.a));
          check("free_done_data", 32'(done_data_f), 32'(c.d));
        end
      end
      prev_h = done_h;
      prev_f = done_f;
    end
  endtask

  // Inputs change at the falling edge, are sampled at the next rising edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [15:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic push_read(input logic [15:0] d);
    if (tgt != 0) rd_q_f.push_back(d);
    else rd_q_h.push_back(d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [15:0] exp);
    adr = a;
    mem_write = 1'b0;
    push_read(exp);
    step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic cap);
    cap_t c;
    adr = a;
    wdata = d;
    mem_write = 1'b1;
    if (cap) begin
      c.a = a;
      c.d = d;
      if (tgt != 0) cap_q_f.push_back(c);
      else cap_q_h.push_back(c);
    end
    step();
    mem_write = 1'b0;
  endtask

  // Called right after the edge accepting the last beat: two HOLD cycles,
  // RUN entered on the second edge, cpu_reset released on the third.
  task automatic release_seq(input logic [7:0] a, input logic [15:0] exp);
    check("hold_ld_ready", 32'(sel_ld_ready()), 32'd0);
    check("hold_cpu_reset_e0", 32'(sel_cpu_reset()), 32'd1);
    adr = a;
    mem_write = 1'b0;
    step();
    check("hold_cpu_reset_e1", 32'(sel_cpu_reset()), 32'd1);
    step();
    check("hold_cpu_reset_e2", 32'(sel_cpu_reset()), 32'd1);
    push_read(exp);
    step();
    check("run_cpu_reset_e3", 32'(sel_cpu_reset()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    adr = '0; mem_write = 1'b0; wdata = '0;
    rst_halt = 1'b0; rst_free = 1'b0;
    fork
      monitor();
    join_none
    @(negedge clk);
    step();
    step();

    // Reset values of the halting instance
    check("rst_ld_ready", 32'(bus_halt.ld_ready), 32'd0);
    check("rst_cpu_reset", 32'(bus_halt.cpu_reset), 32'd1);
    check("rst_rdata", 32'(bus_halt.rdata), 32'd0);
    check("rst_rdata_oe", 32'(bus_halt.rdata_oe), 32'd0);
    check("rst_done", 32'(done_h), 32'd0);
    check("rst_done_adr", 32'(done_adr_h), 32'd0);
    check("rst_done_data", 32'(done_data_h), 32'd0);
    check("rst_load_count", 32'(load_count_h), 32'd0);

    // Halting instance: 3-beat image, read, first write halts
    tgt = 0;
    rst_halt = 1'b1;
    step();
    check("load_ld_ready", 32'(sel_ld_ready()), 32'd1);
    beat(16'h0001, 1'b0);
    beat(16'h0A02, 1'b0);
    beat(16'h2D00, 1'b1);
    check("a_load_count", sel_load_count(), 32'd3);
    release_seq(8'd1, 16'h0A02);
    rd(8'd0, 16'h0001);
    rd(8'd2, 16'h2D00);
    wr(8'h20, 16'h002D, 1'b1);
    check("a_done", 32'(done_h), 32'd1);
    check("a_halt_cpu_reset", 32'(bus_halt.cpu_reset), 32'd1);
    wr(8'h21, 16'h1234, 1'b0);
    adr = 8'd1;
    step();
    step();
    check("a_hold_done_adr", 32'(done_adr_h), 32'h20);
    check("a_hold_done_data", 32'(done_data_h), 32'h002D);
    check("a_done_cpu_reset", 32'(bus_halt.cpu_reset), 32'd1);
    check("a_done_ld_ready", 32'(bus_halt.ld_ready), 32'd0);

    // Free-running instance: writes keep memory live, capture stays first
    tgt = 1;
    rst_free = 1'b1;
    step();
    beat(16'h1111, 1'b0);
    beat(16'h2222, 1'b0);
    beat(16'h3333, 1'b1);
    check("b_load_count", sel_load_count(), 32'd3);
    release_seq(8'd2, 16'h3333);
    wr(8'd5, 16'h0011, 1'b1);
    check("b_done", 32'(done_f), 32'd1);
    check("b_cpu_reset_low", 32'(bus_free.cpu_reset), 32'd0);
    rd(8'd5, 16'h0011);
    wr(8'd6, 16'h0077, 1'b0);
    rd(8'd6, 16'h0077);
    check("b_done_adr_kept", 32'(done_adr_f), 32'd5);
    check("b_done_data_kept", 32'(done_data_f), 32'h0011);

    // Full-store stream on the halting instance
    #1;
    rst_free = 1'b0;
    rst_halt = 1'b0;
    tgt = 0;
    @(negedge clk);
    rst_halt = 1'b1;
    for (int i = 0; i < 256; i++) beat(16'hA500 | 16'(i), 1'b0);
    check("c_load_count", sel_load_count(), 32'd256);
    ld_valid = 1'b1;
    ld_data  = 16'hFFFF;
    check("c_beat257_ld_ready", 32'(sel_ld_ready()), 32'd0);
    release_seq(8'd0, 16'hA500);
    ld_valid = 1'b0;
    check("c_load_count_after", sel_load_count(), 32'd256);
    rd(8'd255, 16'hA5FF);
    rd(8'd128, 16'hA580);

    // Reset in the middle of a load, then a complete reload
    #1;
    rst_halt = 1'b0;
    step();
    check("d_rst_cpu_reset", 32'(sel_cpu_reset()), 32'd1);
    rst_halt = 1'b1;
    beat(16'hB000, 1'b0);
    beat(16'hB001, 1'b0);
    check("d_partial_count", sel_load_count(), 32'd2);
    check("d_partial_cpu_reset", 32'(sel_cpu_reset()), 32'd1);
    #1;
    rst_halt = 1'b0;
    step();
    check("d_abort_count", sel_load_count(), 32'd0);
    check("d_abort_cpu_reset", 32'(sel_cpu_reset()), 32'd1);
    rst_halt = 1'b1;
    beat(16'hC000, 1'b0);
    check("d_reload_cpu_reset", 32'(sel_cpu_reset()), 32'd1);
    beat(16'hC001, 1'b0);
    beat(16'hC002, 1'b0);
    beat(16'hC003, 1'b1);
    check("d_load_count", sel_load_count(), 32'd4);
    release_seq(8'd0, 16'hC000);
    rd(8'd1, 16'hC001);
    rd(8'd2, 16'hC002);
    rd(8'd3, 16'hC003);
    wr(8'h40, 16'hBEEF, 1'b1);
    check("d_done_cpu_reset", 32'(bus_halt.cpu_reset), 32'd1);
    step();

    check("end_rd_q_halt_empty", 32'(rd_q_h.size()), 32'd0);
    check("end_rd_q_free_empty", 32'(rd_q_f.size()), 32'd0);
    check("end_cap_q_halt_empty", 32'(cap_q_h.size()), 32'd0);
    check("end_cap_q_free_empty", 32'(cap_q_f.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
